// File: rtl/seg7_scan_capture.sv
// Passive readback of a multiplexed active-low 7-segment bus: settles, decodes and frames four digits.
// Optional SEG7_CAPTURE_HEX_EN enables decoding of the A-F glyphs; otherwise they are flagged bad.
module seg7_scan_capture #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clkin,
    input  logic        rst,
    input  logic [6:0]  segments_a_to_g,
    input  logic [3:0]  finanode,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  bad,
    output logic        frame_valid,
    output logic        frame_strobe
);

    localparam int unsigned IN_W   = 11;
    localparam int unsigned STAB_W = 8;
    localparam logic [STAB_W-1:0] SETTLE = STAB_W'(SETTLE_CYCLES);

    logic [IN_W-1:0]   in_raw;
    logic [IN_W-1:0]   in_q;
    logic [STAB_W-1:0] stab;
    logic [STAB_W-1:0] stab_next;
    logic              anode_ok;
    logic [1:0]        pos;
    logic [3:0]        pos_mask;
    logic [3:0]        seen;
    logic [3:0]        seen_set;
    logic              sample;
    logic              publish;
    logic [5:0]        dec;
    logic [15:0]       sh_digits;
    logic [3:0]        sh_blank;
    logic [3:0]        sh_bad;

    // Returns {bad, blank, nibble} for an active-low segment pattern.
    function automatic logic [5:0] decode(input logic [6:0] seg);
        logic [5:0] r;
        r = 6'b10_0000;
        case (seg)
            7'h01: r = 6'h00;
            7'h4F: r = 6'h01;
            7'h12: r = 6'h02;
            7'h06: r = 6'h03;
            7'h4C: r = 6'h04;
            7'h24: r = 6'h05;
            7'h20: r = 6'h06;
            7'h0F: r = 6'h07;
            7'h00: r = 6'h08;
            7'h04: r = 6'h09;
`ifdef SEG7_CAPTURE_HEX_EN
            7'h08: r = 6'h0A;
            7'h60: r = 6'h0B;
            7'h31: r = 6'h0C;
            7'h42: r = 6'h0D;
            7'h30: r = 6'h0E;
            7'h38: r = 6'h0F;
`endif
            7'h7F: r = 6'b01_0000;
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    // Exactly one anode low selects a digit position.
    always_comb begin
        anode_ok = 1'b1;
        pos      = 2'd0;
        case (finanode)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: anode_ok = 1'b0;
        endcase
    end

    // Stability tracking; a sample fires once when the count first reaches SETTLE.
    always_comb begin
        in_raw    = {finanode, segments_a_to_g};
        stab_next = '0;
        if (in_raw == in_q && anode_ok) begin
            stab_next = (stab >= SETTLE) ? stab : stab + STAB_W'(1);
        end
        sample   = (stab_next == SETTLE) && (stab != SETTLE);
        pos_mask = 4'b0001 << pos;
        seen_set = seen | pos_mask;
        dec      = decode(segments_a_to_g);
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            in_q         <= '0;
            stab         <= '0;
            seen         <= '0;
            publish      <= 1'b0;
            sh_digits    <= '0;
            sh_blank     <= '0;
            sh_bad       <= '0;
            digits       <= '0;
            blank        <= '0;
            bad          <= '0;
            frame_valid  <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            in_q         <= in_raw;
            stab         <= stab_next;
            publish      <= 1'b0;
            frame_strobe <= publish;
            // Whole-frame copy keeps the outputs coherent.
            if (publish) begin
                digits      <= sh_digits;
                blank       <= sh_blank;
                bad         <= sh_bad;
                frame_valid <= 1'b1;
            end
            if (sample) begin
                sh_digits[{pos, 2'b00} +: 4] <= dec[3:0];
                sh_blank[pos]                <= dec[4];
                sh_bad[pos]                  <= dec[5];
                if (seen_set == 4'hF) begin
                    seen    <= '0;
                    publish <= 1'b1;
                end else begin
                    seen <= seen_set;
                end
            end
        end
    end

endmodule
